// File: rtl/vlsu_pkg.sv
// Shared types and sizing for the vector load/store address generator.
package vlsu_pkg;

    localparam int busBits      = 512;
    localparam int busBytes     = busBits / 8;
    localparam int addrBits     = 32;
    localparam int metaBufDepth = 4;
    localparam int offBits      = $clog2(busBytes);
    localparam int pageBytes    = 4096;

    // One-hot request mode.
    typedef logic [3:0] mode_oh_t;
    localparam mode_oh_t MODE_INCR  = 4'b0001;
    localparam mode_oh_t MODE_STRD  = 4'b0010;
    localparam mode_oh_t MODE_ROW2D = 4'b0100;
    localparam mode_oh_t MODE_CLN2D = 4'b1000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INCR_GEN = 2'd1,
        STRD_GEN = 2'd2
    } gen_state_t;

    // Per-transaction bookkeeping handed to the data path.
    typedef struct packed {
        logic [offBits-1:0] off;
        logic [12:0]        bytes;
        mode_oh_t           mode;
    } meta_t;

    // True when the low address bits are a multiple of the element size.
    function automatic logic is_aligned(input logic [2:0] addr_lo, input logic [1:0] esz);
        logic [2:0] mask;
        mask = 3'((4'd1 << esz) - 4'd1);
        return (addr_lo & mask) == 3'd0;
    endfunction

endpackage

// File: rtl/vlsu_meta_fifo.sv
// Small in-order FIFO for transaction meta entries; push and pop may
// coincide, including when full.
module vlsu_meta_fifo #(
    parameter int  Depth = 4,
    parameter type T     = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  T     data_i,
    output logic full_o,
    input  logic pop_i,
    output T     data_o,
    output logic empty_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    T                mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count == CntW'(Depth));
    assign empty_o = (count == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? T'('0) : mem[rd_ptr];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vlsu_addr_gen.sv
// Splits vector memory requests into bus transactions: unit-stride requests
// become 4 KB-bounded bursts, strided requests become one beat per element.
// Each issued transaction records its meta entry in an in-order FIFO.
module vlsu_addr_gen #(
    parameter int busBits      = vlsu_pkg::busBits,
    parameter int addrBits     = vlsu_pkg::addrBits,
    parameter int metaBufDepth = vlsu_pkg::metaBufDepth
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  vlsu_pkg::mode_oh_t              req_mode_i,
    input  logic [addrBits-1:0]             req_base_i,
    input  logic signed [addrBits-1:0]      req_stride_i,
    input  logic [1:0]                      req_esz_i,
    input  logic [15:0]                     req_len_i,
    output logic                            txn_valid_o,
    input  logic                            txn_ready_i,
    output logic [addrBits-1:0]             txn_addr_o,
    output logic [7:0]                      txn_len_o,
    output logic [2:0]                      txn_size_o,
    output logic                            meta_valid_o,
    input  logic                            meta_ready_i,
    output logic [$clog2(busBits/8)-1:0]    meta_off_o,
    output logic [12:0]                     meta_bytes_o,
    output vlsu_pkg::mode_oh_t              meta_mode_o,
    output logic                            done_o,
    output logic                            err_o
);

    import vlsu_pkg::*;

    localparam int OffBits = $clog2(busBits / 8);

    gen_state_t                 state_q, state_d;
    logic [addrBits-1:0]        addr_q, addr_d;
    logic signed [addrBits-1:0] stride_q, stride_d;
    // Bytes left (unit-stride) or elements left (strided).
    logic [19:0]                rem_q, rem_d;
    logic [1:0]                 esz_q, esz_d;
    mode_oh_t                   mode_q, mode_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;

    logic [12:0]                page_room;
    logic [12:0]                chunk;
    logic [OffBits-1:0]         addr_off;
    logic [13:0]                span;
    logic                       req_ok;

    meta_t                      meta_in;
    meta_t                      meta_out;
    logic                       fifo_full;
    logic                       fifo_empty;

    // Burst sizing: stop at the page end, count beats from the in-beat offset.
    assign page_room = 13'(pageBytes) - {1'b0, addr_q[11:0]};
    assign chunk     = (rem_q < 20'(page_room)) ? rem_q[12:0] : page_room;
    assign addr_off  = addr_q[OffBits-1:0];
    assign span      = 14'(addr_off) + 14'(chunk);

    assign req_ok = $onehot(req_mode_i)
                 && ((req_mode_i == MODE_INCR) || (req_mode_i == MODE_STRD))
                 && is_aligned(req_base_i[2:0], req_esz_i);

    assign req_ready_o = (state_q == IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;

    // Next-state, request capture and transaction outputs.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        stride_d     = stride_q;
        rem_d        = rem_q;
        esz_d        = esz_q;
        mode_d       = mode_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        txn_valid_o  = 1'b0;
        txn_addr_o   = '0;
        txn_len_o    = '0;
        txn_size_o   = '0;
        meta_in      = '0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (!req_ok) begin
                        err_d = 1'b1;
                    end else if (req_len_i == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d   = req_base_i;
                        stride_d = req_stride_i;
                        esz_d    = req_esz_i;
                        mode_d   = req_mode_i;
                        if (req_mode_i == MODE_INCR) begin
                            rem_d   = 20'(req_len_i) << req_esz_i;
                            state_d = INCR_GEN;
                        end else begin
                            rem_d   = 20'(req_len_i);
                            state_d = STRD_GEN;
                        end
                    end
                end
            end
            INCR_GEN: begin
                txn_valid_o   = !fifo_full;
                txn_addr_o    = addr_q;
                txn_len_o     = 8'((span - 14'd1) >> OffBits);
                txn_size_o    = 3'(OffBits);
                meta_in.off   = offBits'(addr_off);
                meta_in.bytes = chunk;
                meta_in.mode  = mode_q;
                if (!fifo_full && txn_ready_i) begin
                    addr_d = addr_q + addrBits'(chunk);
                    rem_d  = rem_q - 20'(chunk);
                    if (rem_q == 20'(chunk)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            STRD_GEN: begin
                txn_valid_o   = !fifo_full;
                txn_addr_o    = addr_q;
                txn_len_o     = 8'd0;
                txn_size_o    = {1'b0, esz_q};
                meta_in.off   = offBits'(addr_off);
                meta_in.bytes = 13'd1 << esz_q;
                meta_in.mode  = mode_q;
                if (!fifo_full && txn_ready_i) begin
                    addr_d = addr_q + $unsigned(stride_q);
                    rem_d  = rem_q - 20'd1;
                    if (rem_q == 20'd1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and working registers; reset discards any request in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            rem_q    <= '0;
            esz_q    <= '0;
            mode_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            rem_q    <= rem_d;
            esz_q    <= esz_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    vlsu_meta_fifo #(
        .Depth (metaBufDepth),
        .T     (meta_t)
    ) u_meta_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (txn_valid_o && txn_ready_i),
        .data_i  (meta_in),
        .full_o  (fifo_full),
        .pop_i   (meta_ready_i),
        .data_o  (meta_out),
        .empty_o (fifo_empty)
    );

    assign meta_valid_o = !fifo_empty;
    assign meta_off_o   = OffBits'(meta_out.off);
    assign meta_bytes_o = meta_out.bytes;
    assign meta_mode_o  = meta_out.mode;

endmodule

// File: tb/tb_vlsu_addr_gen.sv
// Bench for vlsu_addr_gen: directed scenarios plus randomized requests
// scored against a request-level model of the transaction/meta stream.
module tb_vlsu_addr_gen;
    import vlsu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [3:0]  req_mode_i = '0;
    logic [31:0] req_base_i = '0;
    logic [31:0] req_stride_i = '0;
    logic [1:0]  req_esz_i = '0;
    logic [15:0] req_len_i = '0;
    logic        txn_valid_o;
    logic        txn_ready_i = 1'b0;
    logic [31:0] txn_addr_o;
    logic [7:0]  txn_len_o;
    logic [2:0]  txn_size_o;
    logic        meta_valid_o;
    logic        meta_ready_i = 1'b0;
    logic [5:0]  meta_off_o;
    logic [12:0] meta_bytes_o;
    logic [3:0]  meta_mode_o;
    logic        done_o;
    logic        err_o;

    vlsu_addr_gen dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_mode_i   (req_mode_i),
        .req_base_i   (req_base_i),
        .req_stride_i (req_stride_i),
        .req_esz_i    (req_esz_i),
        .req_len_i    (req_len_i),
        .txn_valid_o  (txn_valid_o),
        .txn_ready_i  (txn_ready_i),
        .txn_addr_o   (txn_addr_o),
        .txn_len_o    (txn_len_o),
        .txn_size_o   (txn_size_o),
        .meta_valid_o (meta_valid_o),
        .meta_ready_i (meta_ready_i),
        .meta_off_o   (meta_off_o),
        .meta_bytes_o (meta_bytes_o),
        .meta_mode_o  (meta_mode_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed { logic [31:0] addr; logic [7:0] len; logic [2:0] size; } txn_rec_t;
    typedef struct packed { logic [5:0] off; logic [12:0] bytes; logic [3:0] mode; } meta_rec_t;

    txn_rec_t  exp_txn[$];
    meta_rec_t exp_meta[$];

    int vectors = 0, miscompares = 0;
    int cyc = 0, txn_cnt = 0, done_cnt = 0, err_cnt = 0;
    int done_cyc = -1, last_hs_cyc = -1, hold_err = 0;
    int tready_mode = 0;          // 0 random, 1 always ready, 2 never ready
    bit meta_hold = 1'b0;
    bit stall_prev = 1'b0;
    txn_rec_t stall_val;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Backpressure driver, updated just after each rising edge.
    always @(posedge clk_i) begin
        #1;
        case (tready_mode)
            0:       txn_ready_i = ($urandom_range(3) != 0);
            1:       txn_ready_i = 1'b1;
            default: txn_ready_i = 1'b0;
        endcase
        meta_ready_i = meta_hold ? 1'b0 : ($urandom_range(2) != 0);
    end

    // Scoreboard: every handshake is matched against the model queues in order.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (txn_valid_o && txn_ready_i) begin
                txn_cnt++;
                last_hs_cyc = cyc;
                vectors++;
                if (exp_txn.size() == 0) begin
                    miscompares++;
                    $display("FAIL txn_unexpected got addr=%h len=%0d size=%0d want none", txn_addr_o, txn_len_o, txn_size_o);
                end else begin
                    txn_rec_t t;
                    t = exp_txn.pop_front();
                    if ({txn_addr_o, txn_len_o, txn_size_o} !== t) begin
                        miscompares++;
                        $display("FAIL txn got addr=%h len=%0d size=%0d want addr=%h len=%0d size=%0d",
                                 txn_addr_o, txn_len_o, txn_size_o, t.addr, t.len, t.size);
                    end
                end
            end
            if (meta_valid_o && meta_ready_i) begin
                vectors++;
                if (exp_meta.size() == 0) begin
                    miscompares++;
                    $display("FAIL meta_unexpected got off=%0d bytes=%0d want none", meta_off_o, meta_bytes_o);
                end else begin
                    meta_rec_t m;
                    m = exp_meta.pop_front();
                    if ({meta_off_o, meta_bytes_o, meta_mode_o} !== m) begin
                        miscompares++;
                        $display("FAIL meta got off=%0d bytes=%0d mode=%b want off=%0d bytes=%0d mode=%b",
                                 meta_off_o, meta_bytes_o, meta_mode_o, m.off, m.bytes, m.mode);
                    end
                end
            end
            if (done_o) begin done_cnt++; done_cyc = cyc; end
            if (err_o) err_cnt++;
            if (stall_prev && (!txn_valid_o || {txn_addr_o, txn_len_o, txn_size_o} !== stall_val)) hold_err++;
            stall_prev = txn_valid_o && !txn_ready_i;
            stall_val  = {txn_addr_o, txn_len_o, txn_size_o};
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Expected transaction/meta stream of one accepted request.
    task automatic model(input logic [3:0] mode, input logic [31:0] base, input logic [31:0] stride,
                         input int esz, input int len);
        longint a, r, room, c, beats;
        logic [31:0] a32;
        if (mode == MODE_INCR) begin
            a = longint'(base);
            r = longint'(len) << esz;
            while (r > 0) begin
                room  = 4096 - (a % 4096);
                c     = (r < room) ? r : room;
                beats = ((a % 64) + c + 63) / 64;
                a32   = 32'(a);
                exp_txn.push_back(txn_rec_t'({a32, 8'(beats - 1), 3'd6}));
                exp_meta.push_back(meta_rec_t'({6'(a % 64), 13'(c), mode}));
                a = (a + c) % 64'h1_0000_0000;
                r = r - c;
            end
        end else begin
            for (int i = 0; i < len; i++) begin
                a32 = base + 32'(i) * stride;
                exp_txn.push_back(txn_rec_t'({a32, 8'd0, 3'(esz)}));
                exp_meta.push_back(meta_rec_t'({a32[5:0], 13'(1 << esz), mode}));
            end
        end
    endtask

    // Present one request; returns just after the accepting edge.
    task automatic send(input logic [3:0] mode, input logic [31:0] base, input logic [31:0] stride,
                        input int esz, input int len, output bit ok);
        int n = 0;
        while (req_ready_o !== 1'b1 && n < 3000) begin @(posedge clk_i); #1; n++; end
        ok = (req_ready_o === 1'b1);
        if (ok) begin
            req_valid_i = 1'b1; req_mode_i = mode; req_base_i = base; req_stride_i = stride;
            req_esz_i = 2'(esz); req_len_i = 16'(len);
            @(posedge clk_i); #1;
            req_valid_i = 1'b0;
        end
    endtask

    // Wait for the request's done pulse and for all its metas to drain.
    task automatic wait_done(input int d0, output bit ok);
        int n = 0;
        while ((done_cnt == d0 || exp_meta.size() != 0) && n < 3000) begin @(posedge clk_i); #1; n++; end
        ok = (done_cnt != d0) && (exp_meta.size() == 0);
    endtask

    task automatic test_reset();
        #2 rst_ni = 1'b0;
        #1;
        vectors++;
        if ({req_ready_o, txn_valid_o, meta_valid_o, done_o, err_o} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_ctrl got rdy/tv/mv/done/err=%b want 10000",
                     {req_ready_o, txn_valid_o, meta_valid_o, done_o, err_o});
        end
        vectors++;
        if ({txn_addr_o, txn_len_o, txn_size_o, meta_off_o, meta_bytes_o, meta_mode_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_data got addr=%h len=%0d off=%0d bytes=%0d want all zero",
                     txn_addr_o, txn_len_o, meta_off_o, meta_bytes_o);
        end
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_incr_page_cross();
        int d0; bit ok, ok2;
        tready_mode = 0;
        model(MODE_INCR, 32'h1000_0FC0, 32'h0, 2, 32);
        d0 = done_cnt;
        send(MODE_INCR, 32'h1000_0FC0, 32'h0, 2, 32, ok);
        vectors++;
        if (!ok || txn_valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL incr_latency got txn_valid=%b want 1", txn_valid_o);
        end
        wait_done(d0, ok2);
        vectors++;
        if (!ok2 || exp_txn.size() != 0 || done_cnt != d0 + 1) begin
            miscompares++;
            $display("FAIL incr_cross got done=%0d left=%0d want done=%0d left=0", done_cnt - d0, exp_txn.size(), 1);
        end
        vectors++;
        if (done_cyc != last_hs_cyc + 1) begin
            miscompares++;
            $display("FAIL done_timing got cycle %0d want %0d", done_cyc, last_hs_cyc + 1);
        end
    endtask

    task automatic test_incr_single();
        int d0; bit ok, ok2;
        model(MODE_INCR, 32'h0000_0020, 32'h0, 0, 100);
        d0 = done_cnt;
        send(MODE_INCR, 32'h0000_0020, 32'h0, 0, 100, ok);
        wait_done(d0, ok2);
        vectors++;
        if (!ok || !ok2 || exp_txn.size() != 0 || done_cnt != d0 + 1) begin
            miscompares++;
            $display("FAIL incr_single got done=%0d left=%0d want done=1 left=0", done_cnt - d0, exp_txn.size());
        end
    endtask

    task automatic test_strd();
        logic [31:0] bases [3] = '{32'h0000_0100, 32'hFFFF_FFF8, 32'h0000_1000};
        logic [31:0] strds [3] = '{32'h0000_0040, 32'h0000_0008, 32'hFFFF_FFFC};
        int eszs [3] = '{3, 3, 2};
        int lens [3] = '{3, 3, 4};
        int d0; bit ok, ok2;
        for (int k = 0; k < 3; k++) begin
            model(MODE_STRD, bases[k], strds[k], eszs[k], lens[k]);
            d0 = done_cnt;
            send(MODE_STRD, bases[k], strds[k], eszs[k], lens[k], ok);
            wait_done(d0, ok2);
            vectors++;
            if (!ok || !ok2 || exp_txn.size() != 0 || done_cnt != d0 + 1) begin
                miscompares++;
                $display("FAIL strd%0d got done=%0d left=%0d want done=1 left=0", k, done_cnt - d0, exp_txn.size());
            end
        end
    endtask

    task automatic test_meta_backpressure();
        int d0, t0; bit ok, ok2;
        tready_mode = 1;
        meta_hold = 1'b1;
        @(posedge clk_i); #1;
        model(MODE_STRD, 32'h0000_0200, 32'h0000_0010, 2, 6);
        d0 = done_cnt; t0 = txn_cnt;
        send(MODE_STRD, 32'h0000_0200, 32'h0000_0010, 2, 6, ok);
        repeat (10) @(posedge clk_i);
        #1;
        vectors++;
        if (!ok || txn_cnt - t0 != 4 || txn_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL meta_full got txns=%0d txn_valid=%b want txns=4 txn_valid=0", txn_cnt - t0, txn_valid_o);
        end
        meta_hold = 1'b0;
        wait_done(d0, ok2);
        vectors++;
        if (!ok2 || txn_cnt - t0 != 6 || exp_txn.size() != 0) begin
            miscompares++;
            $display("FAIL meta_release got txns=%0d left=%0d want txns=6 left=0", txn_cnt - t0, exp_txn.size());
        end
        tready_mode = 0;
    endtask

    task automatic test_errors();
        logic [3:0]  modes [4] = '{MODE_ROW2D, MODE_CLN2D, 4'b0011, MODE_INCR};
        logic [31:0] bases [4] = '{32'h100, 32'h200, 32'h300, 32'h101};
        int t0, e0; bit ok;
        for (int k = 0; k < 4; k++) begin
            t0 = txn_cnt; e0 = err_cnt;
            send(modes[k], bases[k], 32'h0, 2, 8, ok);
            vectors++;
            if (!ok || err_o !== 1'b1 || req_ready_o !== 1'b1 || txn_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL err%0d_pulse got err=%b rdy=%b tv=%b want err=1 rdy=1 tv=0", k, err_o, req_ready_o, txn_valid_o);
            end
            @(posedge clk_i); #1;
            vectors++;
            if (err_o !== 1'b0 || txn_cnt != t0 || err_cnt != e0 + 1) begin
                miscompares++;
                $display("FAIL err%0d_once got err=%b txns=%0d pulses=%0d want err=0 txns=0 pulses=1", k, err_o, txn_cnt - t0, err_cnt - e0);
            end
        end
    endtask

    task automatic test_zero_len();
        logic [3:0] modes [2] = '{MODE_INCR, MODE_STRD};
        int t0, d0; bit ok;
        for (int k = 0; k < 2; k++) begin
            t0 = txn_cnt; d0 = done_cnt;
            send(modes[k], 32'h40, 32'h8, 0, 0, ok);
            vectors++;
            if (!ok || done_o !== 1'b1 || req_ready_o !== 1'b1 || txn_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_len%0d got done=%b rdy=%b tv=%b want 1 1 0", k, done_o, req_ready_o, txn_valid_o);
            end
            @(posedge clk_i); #1;
            vectors++;
            if (done_o !== 1'b0 || txn_cnt != t0 || done_cnt != d0 + 1) begin
                miscompares++;
                $display("FAIL zero_len%0d_after got done=%b txns=%0d want done=0 txns=0", k, done_o, txn_cnt - t0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int d0, n; bit ok, ok2;
        tready_mode = 1;
        model(MODE_INCR, 32'h0000_0040, 32'h0, 0, 64);
        model(MODE_STRD, 32'h0000_0080, 32'h0000_0008, 3, 2);
        d0 = done_cnt;
        send(MODE_INCR, 32'h0000_0040, 32'h0, 0, 64, ok);
        n = 0;
        while (done_o !== 1'b1 && n < 200) begin @(posedge clk_i); #1; n++; end
        vectors++;
        if (!ok || done_o !== 1'b1 || req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready got done=%b rdy=%b want 1 1", done_o, req_ready_o);
        end
        send(MODE_STRD, 32'h0000_0080, 32'h0000_0008, 3, 2, ok);
        vectors++;
        if (!ok || req_ready_o !== 1'b0 || txn_valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_accept got rdy=%b tv=%b want rdy=0 tv=1", req_ready_o, txn_valid_o);
        end
        wait_done(d0 + 1, ok2);
        vectors++;
        if (!ok2 || exp_txn.size() != 0 || done_cnt != d0 + 2) begin
            miscompares++;
            $display("FAIL b2b_done got done=%0d left=%0d want done=2 left=0", done_cnt - d0, exp_txn.size());
        end
        tready_mode = 0;
    endtask

    task automatic test_random();
        logic [3:0] mode; logic [31:0] base, stride;
        int esz, len, d0; bit ok, ok2;
        for (int k = 0; k < 25; k++) begin
            mode   = ($urandom_range(1) != 0) ? MODE_INCR : MODE_STRD;
            esz    = $urandom_range(3);
            base   = $urandom;
            if ($urandom_range(1) != 0) base[11:0] = 12'hFFF - 12'($urandom_range(200));
            base   = base & ~(32'(1 << esz) - 32'd1);
            stride = 32'($urandom_range(512)) - 32'd256;
            len    = (mode == MODE_INCR) ? $urandom_range(1500, 1) : $urandom_range(12, 1);
            tready_mode = $urandom_range(1);
            model(mode, base, stride, esz, len);
            d0 = done_cnt;
            send(mode, base, stride, esz, len, ok);
            wait_done(d0, ok2);
            vectors++;
            if (!ok || !ok2 || exp_txn.size() != 0 || done_cnt != d0 + 1) begin
                miscompares++;
                $display("FAIL rand%0d mode=%b base=%h len=%0d got done=%0d left=%0d want done=1 left=0",
                         k, mode, base, len, done_cnt - d0, exp_txn.size());
            end
        end
        tready_mode = 0;
        vectors++;
        if (hold_err != 0) begin
            miscompares++;
            $display("FAIL txn_hold got %0d unstable stalls want 0", hold_err);
        end
    endtask

    task automatic test_reset_mid();
        int d0; bit ok, ok2;
        tready_mode = 2;
        @(posedge clk_i); #1;
        send(MODE_INCR, 32'h0000_3000, 32'h0, 3, 1000, ok);
        repeat (3) @(posedge clk_i);
        #1;
        vectors++;
        if (!ok || {txn_valid_o, txn_addr_o, txn_len_o, txn_size_o} !== {1'b1, 32'h0000_3000, 8'd63, 3'd6} || hold_err != 0) begin
            miscompares++;
            $display("FAIL stall_hold got tv=%b addr=%h len=%0d holderr=%0d want tv=1 addr=00003000 len=63 holderr=0",
                     txn_valid_o, txn_addr_o, txn_len_o, hold_err);
        end
        #2 rst_ni = 1'b0;
        exp_txn.delete();
        exp_meta.delete();
        #1;
        vectors++;
        if ({req_ready_o, txn_valid_o, meta_valid_o, done_o, err_o} !== 5'b10000 ||
            {txn_addr_o, txn_len_o, txn_size_o, meta_off_o, meta_bytes_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid got rdy/tv/mv/done/err=%b addr=%h len=%0d want 10000 and zero data",
                     {req_ready_o, txn_valid_o, meta_valid_o, done_o, err_o}, txn_addr_o, txn_len_o);
        end
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        tready_mode = 0;
        @(posedge clk_i); #1;
        model(MODE_INCR, 32'h0000_0F80, 32'h0, 1, 200);
        d0 = done_cnt;
        send(MODE_INCR, 32'h0000_0F80, 32'h0, 1, 200, ok);
        wait_done(d0, ok2);
        vectors++;
        if (!ok || !ok2 || exp_txn.size() != 0 || done_cnt != d0 + 1) begin
            miscompares++;
            $display("FAIL after_reset got done=%0d left=%0d want done=1 left=0", done_cnt - d0, exp_txn.size());
        end
    endtask

    initial begin
        test_reset();
        test_incr_page_cross();
        test_incr_single();
        test_strd();
        test_meta_backpressure();
        test_errors();
        test_zero_len();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vlsu_addr_gen.md
VLSU_ADDR_GEN -- requirements
Module: vlsu_addr_gen

Interface
REQ-001 Parameter busBits, default vlsu_pkg::busBits (512), data bus width; busBytes = busBits/8.
REQ-002 Parameter addrBits, default vlsu_pkg::addrBits (32), address width.
REQ-003 Parameter metaBufDepth, default vlsu_pkg::metaBufDepth (4), meta FIFO depth.
REQ-004 clk_i  in  1  single clock; all state on its rising edge.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 req_valid_i / req_ready_o  in/out  1/1  request handshake.
REQ-007 req_mode_i  in  4  mode_oh_t one-hot mode.
REQ-008 req_base_i  in  addrBits  byte base address.
REQ-009 req_stride_i  in  addrBits  byte stride, STRD only, two's complement.
REQ-010 req_esz_i  in  2  log2 element bytes (0..3).
REQ-011 req_len_i  in  16  element count.
REQ-012 txn_valid_o / txn_ready_i  out/in  1/1  AXI-AR/AW-style transaction handshake.
REQ-013 txn_addr_o  out  addrBits;  txn_len_o  out  8 (beats-1);  txn_size_o  out  3.
REQ-014 meta_valid_o / meta_ready_i  out/in  1/1  meta handshake.
REQ-015 meta_off_o  out  log2(busBytes)  first valid byte in first beat;  meta_bytes_o  out  13  valid bytes in transaction;  meta_mode_o  out  4.
REQ-016 done_o  out  1  one-cycle pulse after last transaction of a request issues;  err_o  out  1  one-cycle pulse on rejected request.

Function
REQ-017 The FSM SHALL have states IDLE, INCR_GEN, STRD_GEN; req_ready_o SHALL be 1 only in IDLE.
REQ-018 On request accept: MODE_INCR -> INCR_GEN; MODE_STRD -> STRD_GEN; MODE_ROW2D, MODE_CLN2D, non-one-hot mode, or base not aligned to 1<<esz -> err_o pulse next cycle, stay IDLE, no transaction.
REQ-019 req_len_i = 0 SHALL be accepted, emit no transaction, pulse done_o next cycle, stay IDLE.
REQ-020 INCR_GEN: remaining bytes R = len<<esz, current address A; chunk = min(R, 4096 - A[11:0]); beats = ceil((A mod busBytes + chunk)/busBytes); txn_len_o = beats-1; txn_size_o = log2(busBytes); meta_off_o = A mod busBytes; meta_bytes_o = chunk.
REQ-021 A transaction SHALL never cross a 4 KB boundary; after each handshake A += chunk, R -= chunk; R = 0 -> done_o pulse, IDLE.
REQ-022 STRD_GEN: element i address = base + i*stride (accumulated, wraps modulo 2^addrBits); txn_len_o = 0; txn_size_o = esz; meta_bytes_o = 1<<esz; meta_off_o = address mod busBytes.
REQ-023 txn_valid_o SHALL assert only when the meta FIFO is not full; each txn handshake SHALL push exactly one meta entry in the same cycle.
REQ-024 txn outputs SHALL be held stable while txn_valid_o=1 and txn_ready_i=0.
REQ-025 Meta entries SHALL leave the FIFO in issue order; meta_valid_o = FIFO not empty; push and pop in the same cycle SHALL both occur, including when full.
REQ-026 First txn_valid_o SHALL assert the cycle after request accept (latency 1).
REQ-027 done_o SHALL pulse the cycle after the final txn handshake; the next request may be accepted that cycle.

Reset
REQ-028 Asserting rst_ni SHALL immediately force: IDLE, req_ready_o=1, txn_valid_o=0, meta_valid_o=0, done_o=0, err_o=0, all address/count registers and txn/meta data outputs 0, FIFO empty; in-flight request discarded.

Structure
REQ-029 mode_oh_t, busBits, busBytes, addrBits, metaBufDepth SHALL come from vlsu_pkg; a meta entry struct (off, bytes, mode) SHALL be added to vlsu_pkg.
REQ-030 The meta FIFO SHALL be a sub-module vlsu_meta_fifo (parameterised depth and data type, async active-low reset).

Verification
REQ-031 INCR base 0x10000FC0, esz 2, len 32 -> txn {0x10000FC0, len 0}, {0x10001000, len 0}; meta {off 0, bytes 64} x2; done_o once.
REQ-032 INCR base 0x20, esz 0, len 100 -> one txn {0x20, len 2, size 6}; meta {off 32, bytes 100}.
REQ-033 STRD base 0x100, stride 0x40, esz 3, len 3 -> txns 0x100, 0x140, 0x180, len 0, size 3.
REQ-034 STRD len 6, meta_ready_i held 0 -> exactly 4 txns then txn_valid_o=0; release -> remaining 2 issue, metas in order.
REQ-035 Mode MODE_ROW2D, then base 0x101 with esz 2 -> err_o pulse each, no txn, req_ready_o=1 next cycle.
REQ-036 rst_ni low mid INCR (R > 0) -> all outputs reset values; new INCR request afterward produces correct sequence.
